// File: rtl/pss_peak_pkg.sv
// Shared types and sizing helpers for the PSS peak detector.
package pss_peak_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        TRACK  = 2'd2
    } state_t;

    // Moving-sum width: enough headroom for WINDOW_LEN full-scale magnitudes.
    function automatic int sum_width(input int in_dw, input int window_len);
        return in_dw + $clog2(window_len);
    endfunction

endpackage

// File: rtl/pss_moving_sum.sv
// Circular buffer plus running sum of the last WINDOW_LEN magnitudes, with fill tracking.
module pss_moving_sum
    import pss_peak_pkg::*;
#(
    parameter int IN_DW      = 16,
    parameter int WINDOW_LEN = 16,
    localparam int SUM_W     = sum_width(IN_DW, WINDOW_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [IN_DW-1:0] data,
    output logic [SUM_W-1:0] sum,
    output logic             full,
    output logic             fill_last
);

    localparam int PTR_W  = $clog2(WINDOW_LEN);
    localparam int FILL_W = PTR_W + 1;

    logic [IN_DW-1:0]  hist_r [WINDOW_LEN];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [FILL_W-1:0] fill_cnt_r;
    logic [SUM_W-1:0]  sum_r;
    logic [IN_DW-1:0]  oldest_s;
    logic [SUM_W-1:0]  next_sum_s;

    // Oldest entry leaves the sum as the new sample enters; modular arithmetic never underflows in practice.
    always_comb begin
        oldest_s   = hist_r[wr_ptr_r];
        next_sum_s = sum_r + SUM_W'(data) - SUM_W'(oldest_s);
    end

    // Buffer, pointer, running sum and fill counter update on every valid sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WINDOW_LEN; i++) begin
                hist_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            fill_cnt_r <= '0;
            sum_r      <= '0;
        end else if (valid) begin
            hist_r[wr_ptr_r] <= data;
            wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            sum_r            <= next_sum_s;
            if (fill_cnt_r != FILL_W'(WINDOW_LEN)) begin
                fill_cnt_r <= fill_cnt_r + FILL_W'(1);
            end
        end
    end

    assign sum       = sum_r;
    assign full      = (fill_cnt_r == FILL_W'(WINDOW_LEN));
    assign fill_last = valid && (fill_cnt_r == FILL_W'(WINDOW_LEN - 1));

endmodule

// File: rtl/pss_peak_detector.sv
// PSS correlation peak detector: relative threshold trigger, holdoff max tracking, one report per peak.
// Optional absolute threshold input enabled by PSS_PEAK_ABS_THRESHOLD_EN.
module pss_peak_detector
    import pss_peak_pkg::*;
#(
    parameter int IN_DW            = 16,
    parameter int WINDOW_LEN       = 16,
    parameter int DETECTION_FACTOR = 8,
    parameter int HOLDOFF_LEN      = 64,
    parameter int CNT_W            = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [IN_DW-1:0] s_axis_in_tdata,
    input  logic             s_axis_in_tvalid,
`ifdef PSS_PEAK_ABS_THRESHOLD_EN
    input  logic [IN_DW-1:0] abs_threshold_i,
`endif
    output logic             peak_valid_o,
    output logic [IN_DW-1:0] peak_value_o,
    output logic [CNT_W-1:0] peak_index_o,
    output logic             fill_done_o
);

    localparam int SUM_W  = sum_width(IN_DW, WINDOW_LEN);
    localparam int CMP_W  = SUM_W + 8;
    localparam int HOLD_W = $clog2(HOLDOFF_LEN) + 1;

    state_t            state_r;
    logic [CNT_W-1:0]  idx_r;
    logic [IN_DW-1:0]  max_r;
    logic [CNT_W-1:0]  max_idx_r;
    logic [HOLD_W-1:0] hold_r;
    logic              peak_valid_r;
    logic [IN_DW-1:0]  peak_value_r;
    logic [CNT_W-1:0]  peak_index_r;
    logic              fill_done_r;

    logic [SUM_W-1:0]  sum_s;
    logic              full_s;
    logic              fill_last_s;
    logic [CMP_W-1:0]  lhs_s;
    logic [CMP_W-1:0]  rhs_s;
    logic              abs_ok_s;
    logic              trig_s;
    logic              upd_s;
    logic [IN_DW-1:0]  trk_max_s;
    logic [CNT_W-1:0]  trk_idx_s;

    pss_moving_sum #(
        .IN_DW      (IN_DW),
        .WINDOW_LEN (WINDOW_LEN)
    ) u_moving_sum (
        .clk       (clk_i),
        .reset     (reset_i),
        .valid     (s_axis_in_tvalid),
        .data      (s_axis_in_tdata),
        .sum       (sum_s),
        .full      (full_s),
        .fill_last (fill_last_s)
    );

`ifdef PSS_PEAK_ABS_THRESHOLD_EN
    assign abs_ok_s = (s_axis_in_tdata > abs_threshold_i);
`else
    assign abs_ok_s = 1'b1;
`endif

    // Trigger compares x*WINDOW_LEN against the pre-update sum scaled by the factor, avoiding division.
    always_comb begin
        lhs_s     = CMP_W'(s_axis_in_tdata) * CMP_W'(WINDOW_LEN);
        rhs_s     = CMP_W'(sum_s) * CMP_W'(DETECTION_FACTOR);
        trig_s    = full_s && abs_ok_s && (lhs_s > rhs_s);
        upd_s     = (s_axis_in_tdata > max_r);
        trk_max_s = upd_s ? s_axis_in_tdata : max_r;
        trk_idx_s = upd_s ? idx_r : max_idx_r;
    end

    // Detection FSM, sample index counter and registered peak report.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= FILL;
            idx_r        <= '0;
            max_r        <= '0;
            max_idx_r    <= '0;
            hold_r       <= '0;
            peak_valid_r <= 1'b0;
            peak_value_r <= '0;
            peak_index_r <= '0;
            fill_done_r  <= 1'b0;
        end else begin
            peak_valid_r <= 1'b0;
            if (s_axis_in_tvalid) begin
                idx_r <= idx_r + CNT_W'(1);
                case (state_r)
                    FILL: begin
                        if (fill_last_s) begin
                            state_r     <= SEARCH;
                            fill_done_r <= 1'b1;
                        end
                    end
                    SEARCH: begin
                        if (trig_s) begin
                            if (HOLDOFF_LEN == 1) begin
                                peak_valid_r <= 1'b1;
                                peak_value_r <= s_axis_in_tdata;
                                peak_index_r <= idx_r;
                            end else begin
                                state_r   <= TRACK;
                                max_r     <= s_axis_in_tdata;
                                max_idx_r <= idx_r;
                                hold_r    <= HOLD_W'(HOLDOFF_LEN - 1);
                            end
                        end
                    end
                    TRACK: begin
                        max_r     <= trk_max_s;
                        max_idx_r <= trk_idx_s;
                        if (hold_r == HOLD_W'(1)) begin
                            peak_valid_r <= 1'b1;
                            peak_value_r <= trk_max_s;
                            peak_index_r <= trk_idx_s;
                            state_r      <= SEARCH;
                        end else begin
                            hold_r <= hold_r - HOLD_W'(1);
                        end
                    end
                    default: begin
                        state_r <= FILL;
                    end
                endcase
            end
        end
    end

    assign peak_valid_o = peak_valid_r;
    assign peak_value_o = peak_value_r;
    assign peak_index_o = peak_index_r;
    assign fill_done_o  = fill_done_r;

endmodule

// File: tb/tb_pss_peak_detector.sv
// Directed bench for pss_peak_detector (WINDOW_LEN=4, DETECTION_FACTOR=4, HOLDOFF_LEN=8).
module tb_pss_peak_detector;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] tdata = 16'd0;
    logic        tvalid = 1'b0;
`ifdef PSS_PEAK_ABS_THRESHOLD_EN
    logic [15:0] abs_threshold = 16'd0;
`endif
    logic        peak_valid;
    logic [15:0] peak_value;
    logic [31:0] peak_index;
    logic        fill_done;

    int          errors = 0;
    int          checks = 0;
    int          pulse_cnt = 0;
    logic [15:0] pulse_val = 16'd0;
    logic [31:0] pulse_idx = 32'd0;
    logic [31:0] pulse_after = 32'd0;
    logic [31:0] cons_cnt = 32'd0;

    pss_peak_detector #(
        .IN_DW            (16),
        .WINDOW_LEN       (4),
        .DETECTION_FACTOR (4),
        .HOLDOFF_LEN      (8),
        .CNT_W            (32)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .s_axis_in_tdata  (tdata),
        .s_axis_in_tvalid (tvalid),
`ifdef PSS_PEAK_ABS_THRESHOLD_EN
        .abs_threshold_i  (abs_threshold),
`endif
        .peak_valid_o     (peak_valid),
        .peak_value_o     (peak_value),
        .peak_index_o     (peak_index),
        .fill_done_o      (fill_done)
    );

    always #5 clk = ~clk;

    // Bench-side count of consumed samples, used to locate when a pulse lands.
    always @(posedge clk) begin
        if (reset) cons_cnt <= 32'd0;
        else if (tvalid) cons_cnt <= cons_cnt + 32'd1;
    end

    // Record every cycle the pulse is high, away from the active edge.
    always @(negedge clk) begin
        if (peak_valid) begin
            pulse_cnt   = pulse_cnt + 1;
            pulse_val   = peak_value;
            pulse_idx   = peak_index;
            pulse_after = cons_cnt - 32'd1;
        end
    end

    function automatic logic [15:0] pat(input int i, input bit tie);
        if (i == 10) return 16'd200;
        if (i == 12) return 16'd300;
        if (i == 14 && tie) return 16'd300;
        return 16'd10;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic apply_reset();
        reset = 1'b1;
        tvalid = 1'b0;
        tdata = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [15:0] v);
        tdata = v;
        tvalid = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL reset peak_valid: got %0b want 0", peak_valid); end
        checks++; if (peak_value !== 16'd0) begin errors++; $display("FAIL reset peak_value: got %0d want 0", peak_value); end
        checks++; if (peak_index !== 32'd0) begin errors++; $display("FAIL reset peak_index: got %0d want 0", peak_index); end
        checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL reset fill_done: got %0b want 0", fill_done); end
    endtask

    task automatic test_fill_steady();
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        for (int i = 0; i < 20; i++) begin
            send(16'd10);
            checks++;
            if (fill_done !== (i >= 3)) begin errors++; $display("FAIL steady fill_done after idx %0d: got %0b want %0b", i, fill_done, (i >= 3)); end
        end
        idle(3);
        checks++; if (pulse_cnt - p0 != 0) begin errors++; $display("FAIL steady pulses: got %0d want 0", pulse_cnt - p0); end
    endtask

    task automatic test_peak_gap(input int gap, input bit tie, input string name);
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        for (int i = 0; i < 25; i++) begin
            send(pat(i, tie));
            checks++;
            if (peak_valid !== (i == 17)) begin errors++; $display("FAIL %s peak_valid after idx %0d: got %0b want %0b", name, i, peak_valid, (i == 17)); end
            if (gap > 0) idle(gap);
        end
        idle(3);
        checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL %s pulse count: got %0d want 1", name, pulse_cnt - p0); end
        checks++; if (pulse_val !== 16'd300) begin errors++; $display("FAIL %s pulse value: got %0d want 300", name, pulse_val); end
        checks++; if (pulse_idx !== 32'd12) begin errors++; $display("FAIL %s pulse index: got %0d want 12", name, pulse_idx); end
        checks++; if (pulse_after !== 32'd17) begin errors++; $display("FAIL %s pulse after idx: got %0d want 17", name, pulse_after); end
        checks++; if (peak_value !== 16'd300 || peak_index !== 32'd12) begin errors++; $display("FAIL %s hold: got %0d/%0d want 300/12", name, peak_value, peak_index); end
    endtask

    task automatic test_fill_spike();
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        for (int i = 0; i < 20; i++) begin
            send((i == 2) ? 16'd500 : 16'd10);
            checks++;
            if (peak_valid !== 1'b0) begin errors++; $display("FAIL spike peak_valid after idx %0d: got %0b want 0", i, peak_valid); end
        end
        idle(3);
        checks++; if (pulse_cnt - p0 != 0) begin errors++; $display("FAIL spike pulses: got %0d want 0", pulse_cnt - p0); end
    endtask

    task automatic test_reset_mid_track();
        int p0;
        apply_reset();
        for (int i = 0; i < 14; i++) send(pat(i, 1'b0));
        p0 = pulse_cnt;
        apply_reset();
        idle(12);
        checks++; if (pulse_cnt - p0 != 0) begin errors++; $display("FAIL midreset pulses: got %0d want 0", pulse_cnt - p0); end
        checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL midreset fill_done: got %0b want 0", fill_done); end
        checks++; if (peak_index !== 32'd0) begin errors++; $display("FAIL midreset peak_index: got %0d want 0", peak_index); end
        for (int i = 0; i < 25; i++) begin
            send(pat(i, 1'b0));
            checks++;
            if (fill_done !== (i >= 3)) begin errors++; $display("FAIL midreset fill_done after idx %0d: got %0b want %0b", i, fill_done, (i >= 3)); end
            checks++;
            if (peak_valid !== (i == 17)) begin errors++; $display("FAIL midreset peak_valid after idx %0d: got %0b want %0b", i, peak_valid, (i == 17)); end
        end
        checks++; if (peak_value !== 16'd300 || peak_index !== 32'd12) begin errors++; $display("FAIL midreset report: got %0d/%0d want 300/12", peak_value, peak_index); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            v = (i == 10) ? 16'd200 : ((i == 18) ? 16'd300 : 16'd10);
            send(v);
            checks++;
            if (peak_valid !== (i == 17 || i == 25)) begin errors++; $display("FAIL b2b peak_valid after idx %0d: got %0b want %0b", i, peak_valid, (i == 17 || i == 25)); end
            if (i == 17) begin
                checks++;
                if (peak_value !== 16'd200 || peak_index !== 32'd10) begin errors++; $display("FAIL b2b first report: got %0d/%0d want 200/10", peak_value, peak_index); end
            end
            if (i == 25) begin
                checks++;
                if (peak_value !== 16'd300 || peak_index !== 32'd18) begin errors++; $display("FAIL b2b second report: got %0d/%0d want 300/18", peak_value, peak_index); end
            end
        end
    endtask

`ifdef PSS_PEAK_ABS_THRESHOLD_EN
    task automatic test_abs_threshold();
        int p0;
        abs_threshold = 16'd250;
        apply_reset();
        p0 = pulse_cnt;
        for (int i = 0; i < 25; i++) begin
            send(pat(i, 1'b0));
            checks++;
            if (peak_valid !== (i == 19)) begin errors++; $display("FAIL abs peak_valid after idx %0d: got %0b want %0b", i, peak_valid, (i == 19)); end
        end
        idle(3);
        checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL abs pulse count: got %0d want 1", pulse_cnt - p0); end
        checks++; if (peak_value !== 16'd300 || peak_index !== 32'd12) begin errors++; $display("FAIL abs report: got %0d/%0d want 300/12", peak_value, peak_index); end
        abs_threshold = 16'd0;
    endtask
`endif

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_fill_steady();
        test_peak_gap(0, 1'b0, "peak");
        test_peak_gap(0, 1'b1, "tie");
        test_peak_gap(3, 1'b0, "gaps");
        test_fill_spike();
        test_reset_mid_track();
        test_back_to_back();
`ifdef PSS_PEAK_ABS_THRESHOLD_EN
        test_abs_threshold();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pss_peak_detector.md
Name: pss_peak_detector

Overview:
- Sits directly downstream of the PSS correlator and consumes its stream of unsigned correlation magnitudes (|corr|^2).
- Keeps a moving sum of the last WINDOW_LEN magnitudes and triggers when a sample exceeds DETECTION_FACTOR times the moving average.
- After a trigger, tracks the maximum over a HOLDOFF_LEN-sample window, then reports one peak: value plus absolute sample index.
- Output feeds the timing/SSB-sync stage.

Parameters:
- IN_DW, 16, magnitude width; equals the correlator output width.
- WINDOW_LEN, 16, moving-average length; power of 2, at least 2.
- DETECTION_FACTOR, 8, integer threshold multiplier, 1..255.
- HOLDOFF_LEN, 64, valid samples tracked per trigger, trigger sample included; at least 1.
- CNT_W, 32, sample-index counter width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- s_axis_in_tdata  in  IN_DW  unsigned magnitude
- s_axis_in_tvalid  in  1  sample valid; no backpressure, every valid sample is consumed
- peak_valid_o  out  1  one-cycle pulse per detected peak
- peak_value_o  out  IN_DW  maximum magnitude in the tracked window
- peak_index_o  out  CNT_W  sample index of that maximum
- fill_done_o  out  1  moving window full; detection armed

Behaviour:
- Interface: one clock, clk_i. reset_i is synchronous and active-high. Nothing happens on cycles where s_axis_in_tvalid is low.
- Reset: all outputs 0, sum 0, buffer cleared, sample counter 0, state FILL.
- Sample index: a counter increments on every valid sample. The first sample after reset has index 0. The counter wraps modulo 2^CNT_W.
- Moving sum: circular buffer of WINDOW_LEN samples, width SUM_W = IN_DW + log2(WINDOW_LEN).
  - Each valid sample updates sum <= sum + x - oldest and overwrites the oldest entry.
  - Updates continue in every state.
  - Detection uses the sum before the current sample is included.
- Trigger condition: x*WINDOW_LEN > sum*DETECTION_FACTOR.
  - Full-width unsigned products; no division, no truncation.
  - The comparison is strict, so all-zero input never triggers.
- State FILL:
  - No detection.
  - Move to SEARCH on the valid sample that makes WINDOW_LEN samples buffered.
  - fill_done_o is registered high from the next cycle and stays high until reset.
- State SEARCH:
  - On a valid sample meeting the trigger: go to TRACK, set max = x, max_idx = index, and load the holdoff counter with HOLDOFF_LEN-1.
- State TRACK:
  - Each valid sample decrements the holdoff counter.
  - If x > max, update max and max_idx. On ties the first occurrence is kept.
  - Further triggers are ignored.
  - If HOLDOFF_LEN = 1, the trigger sample completes the window immediately.
- Completion:
  - On the cycle after the valid sample that completes the window, peak_valid_o = 1 for exactly one cycle.
  - peak_value_o and peak_index_o are updated in that same cycle and hold until the next report.
  - State returns to SEARCH. A trigger is possible from the next valid sample onward; back-to-back detection is allowed.
- Reset mid-TRACK: no pulse is emitted and the FSM returns to FILL.
- Counter wrap during TRACK: the reported index is the wrapped value.

Optional Feature:
- Macro: PSS_PEAK_ABS_THRESHOLD_EN.
- When defined:
  - Adds input port abs_threshold_i [IN_DW-1:0].
  - A trigger additionally requires x > abs_threshold_i.
  - abs_threshold_i is sampled with the current valid sample.
- When undefined: the port is absent and only the relative criterion applies.

Decomposition:
- Package pss_peak_pkg holds:
  - the state enum {FILL, SEARCH, TRACK};
  - a function computing SUM_W from IN_DW and WINDOW_LEN.
- One sub-module, pss_moving_sum, holds the circular buffer, the running sum and the fill counter.
  - Outputs: sum before update, and full.
- The top level holds the FSM, the comparison, the index counter and the peak registers.

Test Plan:
(All scenarios use WINDOW_LEN=4, DETECTION_FACTOR=4, HOLDOFF_LEN=8.)
- Steady 10s for 20 samples -> fill_done_o rises the cycle after index 3; peak_valid_o never asserts.
- 10s, then 200 at index 10 and 300 at index 12, then 10s -> single pulse the cycle after index 17 with value 300, index 12.
- Two 300s at indices 12 and 14 inside TRACK -> reported index 12.
- 500 at index 2 during FILL -> no trigger, no pulse.
- reset_i asserted at index 14 mid-TRACK -> no pulse. After release the index restarts at 0 and fill_done_o is 0 until 4 more samples.
- tvalid gaps of 3 cycles between samples in the peak scenario -> same value and index reported; pulse lands one cycle after the 8th tracked valid sample.
- With PSS_PEAK_ABS_THRESHOLD_EN and abs_threshold_i=250 -> 200 does not trigger, 300 triggers; TRACK starts at index 12.
